multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
- Multi-cycle control unit for the MIPS-subset CPU. It replaces single-cycle decode with an FSM (IF, ID, EXE, MEM, WB, HALT).
- Sequences write strobes over several cycles and stalls on a memory-ready handshake.
- Counts retired instructions.
- Sits between the IR (which supplies op/funct) and the multi-cycle datapath: PC, IR, register file, ALU, data memory.

Parameters:
- ALUOP_W, 4: ALUop width. Codes occupy the low 4 bits; upper bits are 0.
- CNT_W, 32: retired-instruction counter width.
- MEM_HS, 1: 1 = wait on mem_ready in IF and MEM; 0 = treat mem_ready as constantly 1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous active-high reset.
- op  in  6  opcode from IR; stable from ID through WB.
- funct  in  6  R-type function field from IR.
- zero  in  1  ALU result == 0.
- sign  in  1  ALU result negative.
- mem_ready  in  1  memory completes the current access this cycle.
- state  out  3  current state: IF=0, ID=1, EXE=2, MEM=3, WB=4, HALT=5.
- PCWrite  out  1  PC load strobe.
- IRWrite  out  1  IR load strobe.
- pcsrc  out  2  PC mux select: 0 = PC+4, 1 = branch target, 2 = jump target.
- ALUop  out  ALUOP_W  ALU function.
- ALUsrcA  out  1  ALU A select: 1 = shamt (sll), 0 = rs.
- ALUsrcB  out  1  ALU B select: 1 = extended immediate, 0 = rt.
- RegDst  out  1  destination register: 1 = rd, 0 = rt.
- ExtSel  out  1  immediate extension: 1 = sign-extend, 0 = zero-extend.
- datasrc  out  1  write-back source: 1 = memory, 0 = ALU.
- mRD  out  1  data memory read strobe.
- mWR  out  1  data memory write strobe.
- Regwrite  out  1  register file write strobe.
- halted  out  1  high in HALT.
- retired  out  CNT_W  count of completed instructions.

Behaviour:
- All state and retired update on the rising clk edge.
- rst sampled high:
  - next state = IF, retired = 0.
  - While rst is high, outputs are forced: all strobes 0, pcsrc 0, selects 0, ALUop 4'b1000, halted 0.
  - Reset mid-access abandons the access; no strobe is issued in the reset cycle.
- Decode tables (active in ID/EXE/MEM/WB; IF/HALT drive defaults of 0 and ALUop 1000):
  - R-type (op 000000): sll(000000) ALUop 0111 with ALUsrcA=1; add(100000) 0100; sub(100010) 0101; and(100100) 0000; or(100101) 0001. All R-type use RegDst=1.
  - I-type, all with ALUsrcB=1 and RegDst=0:
    - addiu(001001): 0100, ExtSel=1.
    - andi(001100): 0000, ExtSel=0.
    - ori(001101): 0001, ExtSel=0.
    - slti(001010): 0110, ExtSel=1.
  - lw(100011) and sw(101011): 0100, ExtSel=1, ALUsrcB=1. lw also sets datasrc=1.
  - Branches, all with ExtSel=1 and ALUsrcB=0: beq(000100) 1000, bne(000101) 1001, bltz(000110) 1010.
  - j(000010), halt(111111).
  - Any other opcode, or an undefined R-type funct, is a NOP: no Regwrite, no memory strobes.
- IF:
  - IRWrite=1, PCWrite=1, pcsrc=0, asserted only in the cycle mem_ready=1.
  - Stay in IF while mem_ready=0.
  - Next state = ID on the cycle mem_ready=1.
- ID: no strobes. Next state by opcode:
  - j: PCWrite=1, pcsrc=2, then IF; retired+1.
  - halt: HALT; retired+1.
  - NOP: IF; retired+1.
  - Otherwise: EXE.
- EXE: selects driven from the decode table. Next state by instruction class:
  - beq/bne: taken when zero=1. Taken: PCWrite=1, pcsrc=1. Then IF; retired+1.
  - bltz: taken when sign=1. Taken: PCWrite=1, pcsrc=1. Then IF; retired+1.
  - lw/sw: MEM.
  - ALU ops: WB.
- MEM:
  - Strobes: sw asserts mWR=1; lw asserts mRD=1. Held until mem_ready=1.
  - Next state: sw goes to IF (retired+1) on mem_ready; lw goes to WB on mem_ready.
- WB: Regwrite=1 for exactly one cycle; datasrc per decode. Next state IF; retired+1.
- HALT:
  - halted=1, all strobes 0.
  - Stays in HALT until rst; mem_ready is ignored.
- Per-instruction cycle counts (MEM_HS=0): j/NOP/halt 2; branch 3; ALU 4; sw 4; lw 5. Each stall cycle adds 1.
- Strobe rules:
  - PCWrite and Regwrite are never high in the same cycle.
  - Each instruction asserts PCWrite at most twice: once in IF, once on a jump or taken branch.
- retired wraps modulo 2^CNT_W; no saturation.
- MEM_HS=0: the IF and MEM states each last exactly 1 cycle.

Test Plan:
- Reset then add (op 000000, funct 100000), mem_ready=1 -> states IF,ID,EXE,WB; ALUop 0100, RegDst 1; Regwrite=1 only in WB; retired=1 after 4 cycles.
- lw (100011) with mem_ready low 2 cycles in MEM -> mRD held 3 cycles; WB has Regwrite=1, datasrc=1; total 7 cycles; sw -> mWR asserted, never Regwrite.
- beq with zero=1 -> PCWrite in EXE, pcsrc=1. beq with zero=0 -> no EXE PCWrite. bltz with sign=1 -> taken. Each case is 3 cycles.
- j (000010) -> PCWrite with pcsrc=2 in ID, back to IF, 2 cycles. Opcode 111011 -> NOP: no strobes, retired increments.
- halt (111111) -> HALT, halted=1, no strobes for 20 cycles despite mem_ready toggling; rst high -> state IF, retired=0.
- rst asserted during MEM of sw with mem_ready=0 -> mWR=0 that cycle, next state IF. CNT_W=4: after 16 retirements retired wraps to 0.

Source files
------------

// File: rtl/multicycle_control.sv
// Multi-cycle control unit for the MIPS-subset CPU.
// Walks each instruction through IF/ID/EXE/MEM/WB. The strobes are combinational
// from the registered state, the IR fields and mem_ready, so a strobe can follow
// the memory handshake within the same cycle. The state and the retired counter
// are updated together in a single clocked block.
module multicycle_control #(
  parameter int ALUOP_W = 4,
  parameter int CNT_W   = 32,
  parameter int MEM_HS  = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [5:0]         op,
  input  logic [5:0]         funct,
  input  logic               zero,
  input  logic               sign,
  input  logic               mem_ready,
  output logic [2:0]         state,
  output logic               PCWrite,
  output logic               IRWrite,
  output logic [1:0]         pcsrc,
  output logic [ALUOP_W-1:0] ALUop,
  output logic               ALUsrcA,
  output logic               ALUsrcB,
  output logic               RegDst,
  output logic               ExtSel,
  output logic               datasrc,
  output logic               mRD,
  output logic               mWR,
  output logic               Regwrite,
  output logic               halted,
  output logic [CNT_W-1:0]   retired
);

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EXE  = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_HALT = 3'd5
  } state_t;

  typedef enum logic [3:0] {
    C_NOP, C_ALU, C_LW, C_SW, C_BEQ, C_BNE, C_BLTZ, C_J, C_HALT
  } iclass_t;

  typedef struct packed {
    iclass_t    cls;
    logic [3:0] alu;
    logic       srca;
    logic       srcb;
    logic       regdst;
    logic       ext;
    logic       dsrc;
  } dec_t;

  state_t st;
  dec_t   dec;
  logic   mrdy;

  // Instruction decode: class plus datapath selects for one op/funct pair.
  function automatic dec_t decode(input logic [5:0] o, input logic [5:0] f);
    dec_t d;
    d.cls    = C_NOP;
    d.alu    = 4'b1000;
    d.srca   = 1'b0;
    d.srcb   = 1'b0;
    d.regdst = 1'b0;
    d.ext    = 1'b0;
    d.dsrc   = 1'b0;
    case (o)
      6'b000000: begin
        d.regdst = 1'b1;
        case (f)
          6'b000000: begin d.cls = C_ALU; d.alu = 4'b0111; d.srca = 1'b1; end
          6'b100000: begin d.cls = C_ALU; d.alu = 4'b0100; end
          6'b100010: begin d.cls = C_ALU; d.alu = 4'b0101; end
          6'b100100: begin d.cls = C_ALU; d.alu = 4'b0000; end
          6'b100101: begin d.cls = C_ALU; d.alu = 4'b0001; end
          default:   begin d.regdst = 1'b0; end
        endcase
      end
      6'b001001: begin d.cls = C_ALU; d.alu = 4'b0100; d.srcb = 1'b1; d.ext = 1'b1; end
      6'b001100: begin d.cls = C_ALU; d.alu = 4'b0000; d.srcb = 1'b1; end
      6'b001101: begin d.cls = C_ALU; d.alu = 4'b0001; d.srcb = 1'b1; end
      6'b001010: begin d.cls = C_ALU; d.alu = 4'b0110; d.srcb = 1'b1; d.ext = 1'b1; end
      6'b100011: begin
        d.cls = C_LW; d.alu = 4'b0100; d.srcb = 1'b1; d.ext = 1'b1; d.dsrc = 1'b1;
      end
      6'b101011: begin d.cls = C_SW; d.alu = 4'b0100; d.srcb = 1'b1; d.ext = 1'b1; end
      6'b000100: begin d.cls = C_BEQ;  d.alu = 4'b1000; d.ext = 1'b1; end
      6'b000101: begin d.cls = C_BNE;  d.alu = 4'b1001; d.ext = 1'b1; end
      6'b000110: begin d.cls = C_BLTZ; d.alu = 4'b1010; d.ext = 1'b1; end
      6'b000010: d.cls = C_J;
      6'b111111: d.cls = C_HALT;
      default:   d.cls = C_NOP;
    endcase
    return d;
  endfunction

  assign dec   = decode(op, funct);
  assign mrdy  = (MEM_HS != 0) ? mem_ready : 1'b1;
  assign state = st;

  // State sequencing and retired-instruction count.
  always_ff @(posedge clk) begin
    if (rst) begin
      st      <= S_IF;
      retired <= '0;
    end else begin
      case (st)
        S_IF: if (mrdy) st <= S_ID;
        S_ID: begin
          case (dec.cls)
            C_J, C_NOP: begin st <= S_IF;   retired <= retired + CNT_W'(1); end
            C_HALT:     begin st <= S_HALT; retired <= retired + CNT_W'(1); end
            default:    st <= S_EXE;
          endcase
        end
        S_EXE: begin
          case (dec.cls)
            C_BEQ, C_BNE, C_BLTZ: begin st <= S_IF; retired <= retired + CNT_W'(1); end
            C_LW, C_SW:           st <= S_MEM;
            default:              st <= S_WB;
          endcase
        end
        S_MEM: begin
          if (mrdy) begin
            if (dec.cls == C_SW) begin
              st      <= S_IF;
              retired <= retired + CNT_W'(1);
            end else begin
              st <= S_WB;
            end
          end
        end
        S_WB: begin
          st      <= S_IF;
          retired <= retired + CNT_W'(1);
        end
        S_HALT:  st <= S_HALT;
        default: st <= S_IF;
      endcase
    end
  end

  // Strobes and selects; all forced to their idle values while rst is high.
  always_comb begin
    PCWrite  = 1'b0;
    IRWrite  = 1'b0;
    pcsrc    = 2'd0;
    ALUop    = ALUOP_W'(4'b1000);
    ALUsrcA  = 1'b0;
    ALUsrcB  = 1'b0;
    RegDst   = 1'b0;
    ExtSel   = 1'b0;
    datasrc  = 1'b0;
    mRD      = 1'b0;
    mWR      = 1'b0;
    Regwrite = 1'b0;
    halted   = 1'b0;
    if (!rst) begin
      if (st == S_ID || st == S_EXE || st == S_MEM || st == S_WB) begin
        ALUop   = ALUOP_W'(dec.alu);
        ALUsrcA = dec.srca;
        ALUsrcB = dec.srcb;
        RegDst  = dec.regdst;
        ExtSel  = dec.ext;
        datasrc = dec.dsrc;
      end
      case (st)
        S_IF: begin
          IRWrite = mrdy;
          PCWrite = mrdy;
        end
        S_ID: begin
          if (dec.cls == C_J) begin
            PCWrite = 1'b1;
            pcsrc   = 2'd2;
          end
        end
        S_EXE: begin
          if (((dec.cls == C_BEQ || dec.cls == C_BNE) && zero) ||
              (dec.cls == C_BLTZ && sign)) begin
            PCWrite = 1'b1;
            pcsrc   = 2'd1;
          end
        end
        S_MEM: begin
          mRD = (dec.cls == C_LW);
          mWR = (dec.cls == C_SW);
        end
        S_WB:    Regwrite = 1'b1;
        S_HALT:  halted = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: one task per scenario, inline checks.
// Main instance uses the handshake and a 4-bit counter; a second instance runs
// without the handshake.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] op = 6'd0;
  logic [5:0] funct = 6'd0;
  logic       zero = 1'b0;
  logic       sign = 1'b0;
  logic       mem_ready = 1'b1;

  logic [2:0] state;
  logic       PCWrite, IRWrite, ALUsrcA, ALUsrcB, RegDst, ExtSel, datasrc;
  logic       mRD, mWR, Regwrite, halted;
  logic [1:0] pcsrc;
  logic [3:0] ALUop;
  logic [3:0] retired;

  logic [2:0]  b_state;
  logic        b_PCWrite, b_IRWrite, b_ALUsrcA, b_ALUsrcB, b_RegDst, b_ExtSel, b_datasrc;
  logic        b_mRD, b_mWR, b_Regwrite, b_halted;
  logic [1:0]  b_pcsrc;
  logic [3:0]  b_ALUop;
  logic [31:0] b_retired;

  logic [4:0] strb;
  logic [4:0] b_strb;
  assign strb   = {PCWrite, IRWrite, mRD, mWR, Regwrite};
  assign b_strb = {b_PCWrite, b_IRWrite, b_mRD, b_mWR, b_Regwrite};

  int n_cmp = 0;
  int n_bad = 0;

  multicycle_control #(.ALUOP_W(4), .CNT_W(4), .MEM_HS(1)) dut (
    .clk(clk), .rst(rst), .op(op), .funct(funct), .zero(zero), .sign(sign),
    .mem_ready(mem_ready), .state(state), .PCWrite(PCWrite), .IRWrite(IRWrite),
    .pcsrc(pcsrc), .ALUop(ALUop), .ALUsrcA(ALUsrcA), .ALUsrcB(ALUsrcB),
    .RegDst(RegDst), .ExtSel(ExtSel), .datasrc(datasrc), .mRD(mRD), .mWR(mWR),
    .Regwrite(Regwrite), .halted(halted), .retired(retired)
  );

  multicycle_control #(.ALUOP_W(4), .CNT_W(32), .MEM_HS(0)) dut_nohs (
    .clk(clk), .rst(rst), .op(op), .funct(funct), .zero(zero), .sign(sign),
    .mem_ready(mem_ready), .state(b_state), .PCWrite(b_PCWrite), .IRWrite(b_IRWrite),
    .pcsrc(b_pcsrc), .ALUop(b_ALUop), .ALUsrcA(b_ALUsrcA), .ALUsrcB(b_ALUsrcB),
    .RegDst(b_RegDst), .ExtSel(b_ExtSel), .datasrc(b_datasrc), .mRD(b_mRD), .mWR(b_mWR),
    .Regwrite(b_Regwrite), .halted(b_halted), .retired(b_retired)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; zero = 1'b0; sign = 1'b0; mem_ready = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; op = 6'b101011; mem_ready = 1'b1;
    step();
    #1;
    n_cmp++;
    if ({state, retired} !== {3'd0, 4'd0}) begin
      n_bad++; $display("FAIL reset_state: got st=%0d ret=%0d want st=0 ret=0", state, retired);
    end
    n_cmp++;
    if ({strb, pcsrc, ALUop, ALUsrcA, ALUsrcB, RegDst, ExtSel, datasrc, halted} !==
        {5'b0, 2'd0, 4'b1000, 6'b0}) begin
      n_bad++; $display("FAIL reset_outputs: got strb=%b pcsrc=%0d aluop=%b halted=%b want 0/0/1000/0",
                        strb, pcsrc, ALUop, halted);
    end
    rst = 1'b0;
  endtask

  task automatic test_add();
    logic [2:0] es[4];
    logic [4:0] ek[4];
    es = '{3'd0, 3'd1, 3'd2, 3'd4};
    ek = '{5'b11000, 5'b00000, 5'b00000, 5'b00001};
    do_reset();
    op = 6'b000000; funct = 6'b100000; mem_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      n_cmp++;
      if ({state, strb} !== {es[c], ek[c]}) begin
        n_bad++; $display("FAIL add_cycle%0d: got st=%0d strb=%b want st=%0d strb=%b", c, state, strb, es[c], ek[c]);
      end
      if (c == 2) begin
        n_cmp++;
        if ({ALUop, RegDst} !== 5'b01001) begin
          n_bad++; $display("FAIL add_exe_sel: got aluop=%b regdst=%b want 0100/1", ALUop, RegDst);
        end
      end
      step();
    end
    n_cmp++;
    if ({state, retired} !== {3'd0, 4'd1}) begin
      n_bad++; $display("FAIL add_done: got st=%0d ret=%0d want 0/1", state, retired);
    end
  endtask

  task automatic test_lw_sw();
    logic [2:0] es[7];
    logic [4:0] ek[7];
    logic       em[7];
    logic [2:0] ss[4];
    logic [4:0] sk[4];
    es = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd3, 3'd3, 3'd4};
    ek = '{5'b11000, 5'b0, 5'b0, 5'b00100, 5'b00100, 5'b00100, 5'b00001};
    em = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    do_reset();
    op = 6'b100011; funct = 6'd0;
    for (int c = 0; c < 7; c++) begin
      mem_ready = em[c];
      #1;
      n_cmp++;
      if ({state, strb} !== {es[c], ek[c]}) begin
        n_bad++; $display("FAIL lw_cycle%0d: got st=%0d strb=%b want st=%0d strb=%b", c, state, strb, es[c], ek[c]);
      end
      if (c == 6) begin
        n_cmp++;
        if (datasrc !== 1'b1) begin
          n_bad++; $display("FAIL lw_datasrc: got %b want 1", datasrc);
        end
      end
      step();
    end
    n_cmp++;
    if ({state, retired} !== {3'd0, 4'd1}) begin
      n_bad++; $display("FAIL lw_done: got st=%0d ret=%0d want 0/1", state, retired);
    end
    ss = '{3'd0, 3'd1, 3'd2, 3'd3};
    sk = '{5'b11000, 5'b0, 5'b0, 5'b00010};
    do_reset();
    op = 6'b101011; mem_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      n_cmp++;
      if ({state, strb} !== {ss[c], sk[c]}) begin
        n_bad++; $display("FAIL sw_cycle%0d: got st=%0d strb=%b want st=%0d strb=%b", c, state, strb, ss[c], sk[c]);
      end
      step();
    end
    n_cmp++;
    if ({state, retired} !== {3'd0, 4'd1}) begin
      n_bad++; $display("FAIL sw_done: got st=%0d ret=%0d want 0/1", state, retired);
    end
  endtask

  task automatic test_branch();
    logic [5:0] bo[5];
    logic       bz[5];
    logic       bs[5];
    logic       bt[5];
    bo = '{6'b000100, 6'b000100, 6'b000110, 6'b000110, 6'b000101};
    bz = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    bs = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    bt = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 5; i++) begin
      do_reset();
      op = bo[i]; zero = bz[i]; sign = bs[i];
      step();
      step();
      #1;
      n_cmp++;
      if ({state, strb, pcsrc} !== {3'd2, (bt[i] ? 5'b10000 : 5'b00000), (bt[i] ? 2'd1 : 2'd0)}) begin
        n_bad++; $display("FAIL branch%0d_exe: got st=%0d strb=%b pcsrc=%0d want taken=%b", i, state, strb, pcsrc, bt[i]);
      end
      step();
      n_cmp++;
      if ({state, retired} !== {3'd0, 4'd1}) begin
        n_bad++; $display("FAIL branch%0d_done: got st=%0d ret=%0d want 0/1", i, state, retired);
      end
    end
  endtask

  task automatic test_jump_nop();
    logic [5:0] jo[3];
    logic [5:0] jf[3];
    logic       jj[3];
    jo = '{6'b000010, 6'b111011, 6'b000000};
    jf = '{6'd0, 6'd0, 6'b000001};
    jj = '{1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 3; i++) begin
      do_reset();
      op = jo[i]; funct = jf[i];
      step();
      #1;
      n_cmp++;
      if ({state, strb, pcsrc} !== {3'd1, (jj[i] ? 5'b10000 : 5'b00000), (jj[i] ? 2'd2 : 2'd0)}) begin
        n_bad++; $display("FAIL jn%0d_id: got st=%0d strb=%b pcsrc=%0d want jump=%b", i, state, strb, pcsrc, jj[i]);
      end
      step();
      n_cmp++;
      if ({state, retired} !== {3'd0, 4'd1}) begin
        n_bad++; $display("FAIL jn%0d_done: got st=%0d ret=%0d want 0/1", i, state, retired);
      end
    end
  endtask

  task automatic test_halt();
    do_reset();
    op = 6'b111111; funct = 6'd0;
    step();
    #1;
    n_cmp++;
    if ({state, strb} !== {3'd1, 5'b0}) begin
      n_bad++; $display("FAIL halt_id: got st=%0d strb=%b want 1/00000", state, strb);
    end
    step();
    for (int c = 0; c < 20; c++) begin
      mem_ready = c[0];
      #1;
      n_cmp++;
      if ({state, halted, strb} !== {3'd5, 1'b1, 5'b0}) begin
        n_bad++; $display("FAIL halt_hold%0d: got st=%0d halted=%b strb=%b want 5/1/00000", c, state, halted, strb);
      end
      step();
    end
    n_cmp++;
    if (retired !== 4'd1) begin
      n_bad++; $display("FAIL halt_retired: got %0d want 1", retired);
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if (halted !== 1'b0) begin
      n_bad++; $display("FAIL halt_rst_forced: got halted=%b want 0", halted);
    end
    step();
    rst = 1'b0;
    n_cmp++;
    if ({state, retired} !== {3'd0, 4'd0}) begin
      n_bad++; $display("FAIL halt_rst: got st=%0d ret=%0d want 0/0", state, retired);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    op = 6'b101011; mem_ready = 1'b1;
    step();
    step();
    step();
    mem_ready = 1'b0;
    #1;
    n_cmp++;
    if ({state, mWR} !== {3'd3, 1'b1}) begin
      n_bad++; $display("FAIL rmid_mem: got st=%0d mwr=%b want 3/1", state, mWR);
    end
    step();
    rst = 1'b1;
    #1;
    n_cmp++;
    if (strb !== 5'b0) begin
      n_bad++; $display("FAIL rmid_strobes: got %b want 00000", strb);
    end
    step();
    rst = 1'b0;
    n_cmp++;
    if ({state, retired} !== {3'd0, 4'd0}) begin
      n_bad++; $display("FAIL rmid_after: got st=%0d ret=%0d want 0/0", state, retired);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    op = 6'b111011; mem_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      step();
      step();
      if (i == 14) begin
        n_cmp++;
        if (retired !== 4'd15) begin
          n_bad++; $display("FAIL wrap_15: got %0d want 15", retired);
        end
      end
    end
    n_cmp++;
    if ({state, retired} !== {3'd0, 4'd0}) begin
      n_bad++; $display("FAIL wrap_0: got st=%0d ret=%0d want 0/0", state, retired);
    end
  endtask

  task automatic test_decode();
    logic [5:0] dop[13];
    logic [5:0] dfn[13];
    logic [7:0] dex[13];
    dop = '{6'b000000, 6'b000000, 6'b000000, 6'b000000, 6'b000000, 6'b001001, 6'b001100,
            6'b001101, 6'b001010, 6'b100011, 6'b101011, 6'b000101, 6'b000110};
    dfn = '{6'b000000, 6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'd0, 6'd0,
            6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0};
    dex = '{8'b0111_1010, 8'b0100_0010, 8'b0101_0010, 8'b0000_0010, 8'b0001_0010,
            8'b0100_0101, 8'b0000_0100, 8'b0001_0100, 8'b0110_0101, 8'b0100_0101,
            8'b0100_0101, 8'b1001_0001, 8'b1010_0001};
    for (int i = 0; i < 13; i++) begin
      do_reset();
      op = dop[i]; funct = dfn[i];
      step();
      step();
      #1;
      n_cmp++;
      if ({state, ALUop, ALUsrcA, ALUsrcB, RegDst, ExtSel} !== {3'd2, dex[i]}) begin
        n_bad++; $display("FAIL decode%0d: got st=%0d sel=%b%b%b%b%b want st=2 sel=%b", i, state,
                          ALUop, ALUsrcA, ALUsrcB, RegDst, ExtSel, dex[i]);
      end
    end
  endtask

  task automatic test_no_handshake();
    logic [2:0] es[4];
    logic [4:0] ek[4];
    es = '{3'd0, 3'd1, 3'd2, 3'd4};
    ek = '{5'b11000, 5'b0, 5'b0, 5'b00001};
    do_reset();
    op = 6'b000000; funct = 6'b100000; mem_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #1;
      n_cmp++;
      if ({b_state, b_strb} !== {es[c], ek[c]}) begin
        n_bad++; $display("FAIL nohs_cycle%0d: got st=%0d strb=%b want st=%0d strb=%b", c, b_state, b_strb, es[c], ek[c]);
      end
      if (c == 2) begin
        n_cmp++;
        if ({b_ALUop, b_ALUsrcA, b_ALUsrcB, b_RegDst, b_ExtSel, b_datasrc, b_halted, b_pcsrc} !==
            {4'b0100, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0}) begin
          n_bad++; $display("FAIL nohs_exe_sel: got aluop=%b regdst=%b pcsrc=%0d want 0100/1/0", b_ALUop, b_RegDst, b_pcsrc);
        end
      end
      step();
    end
    n_cmp++;
    if ({b_state, b_retired} !== {3'd0, 32'd1}) begin
      n_bad++; $display("FAIL nohs_done: got st=%0d ret=%0d want 0/1", b_state, b_retired);
    end
    n_cmp++;
    if ({state, IRWrite} !== {3'd0, 1'b0}) begin
      n_bad++; $display("FAIL hs_stall_if: got st=%0d irwrite=%b want 0/0", state, IRWrite);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_lw_sw();
    test_branch();
    test_jump_nop();
    test_halt();
    test_reset_mid();
    test_wrap();
    test_decode();
    test_no_handshake();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
